// File: rtl/mc_main_control_if.sv
// Control/status bundle between the multicycle main control FSM (master)
// and the datapath/memory side (slave).
interface mc_main_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic [1:0] funct_sel;
  logic       illegal_op;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, funct_sel, illegal_op, bus_err, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, funct_sel, illegal_op, bus_err, state
  );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM with memory-ready stall and timeout abort.
module mc_main_control #(
  parameter int BUS_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  mc_main_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, IEXEC = 4'd9,
    IWB = 4'd10, JUMP = 4'd11, JAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_REGIMM = 6'b000001, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011;
  localparam logic [7:0] TO_LAST = 8'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  state_t     st, nxt;
  logic [5:0] op_q;
  logic [7:0] wcnt;
  logic       wait_st, timeout, ill;

  assign wait_st = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
  assign timeout = (BUS_TIMEOUT != 0) && wait_st && !bus.mem_ready && (wcnt == TO_LAST);

  // State, latched opcode and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= FETCH;
      op_q <= '0;
      wcnt <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE) op_q <= bus.op;
      if (!wait_st || bus.mem_ready || timeout || nxt != st) wcnt <= '0;
      else if (wcnt != 8'hff)                                wcnt <= wcnt + 8'd1;
    end
  end

  always_comb begin
    nxt = FETCH;
    ill = 1'b0;
    case (st)
      FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:                                 nxt = MEMADR;
          OP_R:                                         nxt = REXEC;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:  nxt = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:                     nxt = IEXEC;
          OP_J:                                         nxt = JUMP;
          OP_JAL:                                       nxt = JAL;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = bus.mem_ready ? FETCH : MEMWR;
      REXEC:  nxt = RWB;
      IEXEC:  nxt = IWB;
      default: nxt = FETCH;
    endcase
    if (timeout) nxt = FETCH;
  end

  logic       pcw, pcwc, iord, mrd, mwr, irw, rw, asa, aop1, aop0;
  logic [1:0] mtr, rdst, asb, pcs, fsel;

  always_comb begin
    {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, aop1, aop0} = '0;
    {mtr, rdst, asb, pcs, fsel} = '0;
    case (st)
      FETCH: begin
        mrd = 1'b1; asb = 2'b01; fsel = 2'b10;
        irw = bus.mem_ready; pcw = bus.mem_ready;
      end
      DECODE: begin asb = 2'b11; fsel = 2'b10; end
      MEMADR: begin asa = 1'b1; asb = 2'b10; fsel = 2'b10; end
      MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      MEMWB:  begin rw = 1'b1; mtr = 2'b01; end
      MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      REXEC:  begin asa = 1'b1; aop1 = 1'b1; end
      RWB:    begin rw = 1'b1; rdst = 2'b01; end
      BRANCH: begin
        asa = 1'b1; pcwc = 1'b1; pcs = 2'b01;
        if (op_q == OP_BEQ) aop0 = 1'b1;
        else                fsel = 2'b01;
      end
      IEXEC:  begin asa = 1'b1; asb = 2'b10; fsel = 2'b01; end
      IWB:    rw = 1'b1;
      JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
      JAL: begin
        pcw = 1'b1; pcs = 2'b10; rw = 1'b1; rdst = 2'b10; mtr = 2'b10;
      end
      default: ;
    endcase
  end

  // Write enables and pulses are gated by rst_n so nothing commits once reset falls
  assign bus.pcwrite     = pcw  & rst_n;
  assign bus.pcwritecond = pcwc & rst_n;
  assign bus.irwrite     = irw  & rst_n;
  assign bus.memwrite    = mwr  & rst_n;
  assign bus.regwrite    = rw   & rst_n;
  assign bus.illegal_op  = ill  & rst_n;
  assign bus.bus_err     = timeout & rst_n;
  assign bus.iord        = iord;
  assign bus.memread     = mrd;
  assign bus.memtoreg    = mtr;
  assign bus.regdst      = rdst;
  assign bus.alusrca     = asa;
  assign bus.alusrcb     = asb;
  assign bus.pcsource    = pcs;
  assign bus.aluop1      = aop1;
  assign bus.aluop0      = aop0;
  assign bus.funct_sel   = fsel;
  assign bus.state       = st;
endmodule

// File: tb/tb_mc_main_control.sv
// Directed, table-driven check of the multicycle main control FSM.
module tb_mc_main_control;
  logic clk = 1'b0;
  logic rst_n;
  mc_main_control_if bus ();

  mc_main_control #(.BUS_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, JL = 6'b000011, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101,
                         LW = 6'b100011, SW = 6'b101011, BAD = 6'b111111;

  // Field order: pcw pcwc iord mrd mwr irw _ mtr _ rdst _ rw asa _ asb _ pcs _ aluop _ fsel _ ill berr
  localparam logic [21:0]
    F1     = 22'b100101_00_00_00_01_00_00_10_00,
    F0     = 22'b000100_00_00_00_01_00_00_10_00,
    F0E    = 22'b000100_00_00_00_01_00_00_10_01,
    DEC    = 22'b000000_00_00_00_11_00_00_10_00,
    DECI   = 22'b000000_00_00_00_11_00_00_10_10,
    MADR   = 22'b000000_00_00_01_10_00_00_10_00,
    MRD    = 22'b001100_00_00_00_00_00_00_00_00,
    MWB    = 22'b000000_01_00_10_00_00_00_00_00,
    MWR    = 22'b001010_00_00_00_00_00_00_00_00,
    MWRE   = 22'b001010_00_00_00_00_00_00_00_01,
    REX    = 22'b000000_00_00_01_00_00_10_00_00,
    RWBV   = 22'b000000_00_01_10_00_00_00_00_00,
    BRBEQ  = 22'b010000_00_00_01_00_01_01_00_00,
    BROTH  = 22'b010000_00_00_01_00_01_00_01_00,
    IEX    = 22'b000000_00_00_01_10_00_00_01_00,
    IWBV   = 22'b000000_00_00_10_00_00_00_00_00,
    JALV   = 22'b100000_10_10_10_00_10_00_00_00,
    JMPV   = 22'b100000_00_00_00_00_10_00_00_00;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [21:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  logic [21:0] ctl_act;

  assign ctl_act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                    bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                    bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0, bus.funct_sel,
                    bus.illegal_op, bus.bus_err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic m, input logic [3:0] s, input logic [21:0] c);
    tbl.push_back('{op: o, mr: m, st: s, ctl: c});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op = R;
    bus.mem_ready = 1'b1;

    // lw with one stall cycle in MEMRD
    add(LW, 1, 0, F1); add(LW, 1, 1, DEC); add(LW, 1, 2, MADR);
    add(LW, 0, 3, MRD); add(LW, 1, 3, MRD); add(LW, 1, 4, MWB);
    add(R, 1, 0, F1); add(R, 1, 1, DEC); add(R, 1, 6, REX); add(R, 1, 7, RWBV);
    add(ADDI, 1, 0, F1); add(ADDI, 1, 1, DEC); add(ADDI, 1, 9, IEX); add(ADDI, 1, 10, IWBV);
    add(BEQ, 1, 0, F1); add(BEQ, 1, 1, DEC); add(BEQ, 1, 8, BRBEQ);
    add(BNE, 1, 0, F1); add(BNE, 1, 1, DEC); add(BNE, 1, 8, BROTH);
    add(JL, 1, 0, F1); add(JL, 1, 1, DEC); add(JL, 1, 12, JALV);
    add(J, 1, 0, F1); add(J, 1, 1, DEC); add(J, 1, 11, JMPV);
    add(BAD, 1, 0, F1); add(BAD, 1, 1, DECI);
    // sw timing out in MEMWR on its 4th cycle
    add(SW, 1, 0, F1); add(SW, 1, 1, DEC); add(SW, 1, 2, MADR);
    add(SW, 0, 5, MWR); add(SW, 0, 5, MWR); add(SW, 0, 5, MWR); add(SW, 0, 5, MWRE);
    // sw with mem_ready arriving in the timeout cycle
    add(SW, 1, 0, F1); add(SW, 1, 1, DEC); add(SW, 1, 2, MADR);
    add(SW, 0, 5, MWR); add(SW, 0, 5, MWR); add(SW, 0, 5, MWR); add(SW, 1, 5, MWR);
    // fetch timeout re-issues the fetch, then ori completes
    add(ORI, 0, 0, F0); add(ORI, 0, 0, F0); add(ORI, 0, 0, F0); add(ORI, 0, 0, F0E);
    add(ORI, 1, 0, F1); add(ORI, 1, 1, DEC); add(ORI, 1, 9, IEX); add(ORI, 1, 10, IWBV);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_ctl", 32'(ctl_act), 32'(F0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus.op = tbl[i].op;
      bus.mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_act), 32'(tbl[i].ctl));
      @(negedge clk);
    end

    // Reset asserted in the middle of REXEC, released with memory ready
    bus.op = R;
    bus.mem_ready = 1'b1;
    #1;
    chk("pre_fetch_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_rexec_state", 32'(bus.state), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_state", 32'(bus.state), 32'd0);
    chk("rst_mid_regwrite", 32'(bus.regwrite), 32'd0);
    chk("rst_mid_ctl", 32'(ctl_act), 32'(F0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_irwrite", 32'(bus.irwrite), 32'd1);
    chk("post_rst_pcwrite", 32'(bus.pcwrite), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_decode", 32'(bus.state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the 32-bit MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables, mux selects and the aluop1/aluop0 pair, plus an ALU-control function-field select, into the ALU control decoder directly downstream.
- Adds a memory ready handshake with timeout, so instruction and data memories may stall.

Parameters:
BUS_TIMEOUT, 255, cycles waited for mem_ready in a memory state before abort (0 = never abort; max 255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  6  opcode field from instruction register
mem_ready  input  1  memory completes current read/write this cycle
pcwrite  output  1  unconditional PC load
pcwritecond  output  1  PC load qualified by ALU branch result
iord  output  1  memory address select: 0 PC, 1 ALUOut
memread  output  1  memory read request
memwrite  output  1  memory write request
irwrite  output  1  instruction register load
memtoreg  output  2  writeback data: 00 ALUOut, 01 MDR, 10 PC
regdst  output  2  dest reg: 00 rt, 01 rd, 10 r31
regwrite  output  1  register file write
alusrca  output  1  ALU A: 0 PC, 1 rs
alusrcb  output  2  ALU B: 00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
pcsource  output  2  PC source: 00 ALU, 01 ALUOut, 10 jump target
aluop1  output  1  ALU control op bit 1
aluop0  output  1  ALU control op bit 0
funct_sel  output  2  ALU-control function field: 00 instr funct[3:0], 01 op_q[3:0], 10 forced 4'b0000
illegal_op  output  1  one-cycle pulse: unsupported opcode decoded
bus_err  output  1  one-cycle pulse: memory timeout abort
state  output  4  current state encoding (debug)

Behaviour:
- Reset: rst_n low -> state=FETCH, op_q=0, wait counter=0.
- Reset forces pcwrite, pcwritecond, irwrite, memwrite, regwrite, illegal_op and bus_err to 0.
- Other outputs follow the FETCH decode during reset.
- Reset mid-instruction abandons it immediately; no partial write may occur after rst_n falls.
- Outputs are Moore, decoded from state (and op_q where noted); all unlisted outputs are 0.
- op_q is registered on exit from DECODE; later states use op_q only.
- Opcodes: R 000000, regimm 000001, j 000010, jal 000011, beq 000100, bne 000101, blez 000110, bgtz 000111, addi 001000, andi 001100, ori 001101, lw 100011, sw 101011.
- States and outputs:
- 0 FETCH: memread=1, alusrcb=01, funct_sel=10, aluop=00; irwrite=pcwrite=mem_ready. Stays in FETCH until mem_ready, then -> DECODE.
- 1 DECODE: alusrcb=11, funct_sel=10. Next state: lw/sw->MEMADR, R->REXEC, beq/bne/blez/bgtz/regimm->BRANCH, addi/andi/ori->IEXEC, j->JUMP, jal->JAL. Any other opcode: illegal_op=1 this cycle, -> FETCH.
- 2 MEMADR: alusrca=1, alusrcb=10, funct_sel=10 -> MEMRD (lw) or MEMWR (sw).
- 3 MEMRD: memread=1, iord=1; waits for mem_ready -> MEMWB.
- 4 MEMWB: regwrite=1, memtoreg=01, regdst=00 -> FETCH.
- 5 MEMWR: memwrite=1, iord=1; waits for mem_ready -> FETCH.
- 6 REXEC: alusrca=1, alusrcb=00, aluop=10, funct_sel=00 -> RWB.
- 7 RWB: regwrite=1, regdst=01 -> FETCH.
- 8 BRANCH: alusrca=1, alusrcb=00, pcwritecond=1, pcsource=01 -> FETCH. beq: aluop=01. Other branches: aluop=00, funct_sel=01.
- 9 IEXEC: alusrca=1, alusrcb=10, aluop=00, funct_sel=01 -> IWB.
- 10 IWB: regwrite=1, regdst=00 -> FETCH.
- 11 JUMP: pcwrite=1, pcsource=10 -> FETCH.
- 12 JAL: pcwrite=1, pcsource=10, regwrite=1, regdst=10, memtoreg=10 -> FETCH. r31 receives the pre-jump PC, already PC+4 from FETCH.
- Encodings 13-15 are unreachable; if entered -> FETCH next cycle with no enables asserted.
- Wait counter, 8 bits: counts cycles spent in FETCH, MEMRD or MEMWR without mem_ready; clears on any state change or on mem_ready.
- Timeout: BUS_TIMEOUT>0 and counter==BUS_TIMEOUT-1 with mem_ready=0 -> bus_err=1 that cycle, next state FETCH, counter clears. In FETCH the timeout re-issues the fetch.
- mem_ready in the timeout cycle wins: normal transition, no bus_err.
- CPI: R/addi/andi/ori 4, lw 5, sw 4, branch/j/jal 3 (zero-wait memory).

Test Plan:
- rst_n low mid-REXEC -> state=0 within same cycle, regwrite=0; release with mem_ready=1 -> irwrite=pcwrite=1 first cycle.
- lw (op=100011), mem_ready always 1 -> states 0,1,2,3,4,0; MEMWB regwrite=1, memtoreg=01, regdst=00; MEMADR funct_sel=10, aluop=00.
- R-type then addi -> REXEC aluop=10, funct_sel=00; IEXEC aluop=00, funct_sel=01; RWB regdst=01, IWB regdst=00.
- beq, bne, jal -> BRANCH: beq aluop=01, bne aluop=00 funct_sel=01, pcwritecond=1, pcsource=01. JAL: pcwrite=1, regdst=10, memtoreg=10.
- op=111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no writes asserted.
- sw, BUS_TIMEOUT=4, mem_ready=0 -> 4 cycles in MEMWR, bus_err pulse on 4th, -> FETCH. Repeat with mem_ready=1 on 4th cycle -> no bus_err.
